// File: rtl/calc_pkg.sv
// Shared definitions for the iterative inverse calculator: widths, FSM
// state encoding, opcode values and the restoring-division trial step.
package calc_pkg;

  localparam int CALC_NBITS    = 16;
  localparam int CALC_CNT_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } calc_state_t;

  localparam logic CALC_OP_SUB = 1'b0;
  localparam logic CALC_OP_DIV = 1'b1;

  // One restoring-division trial. 'shifted' is the partial remainder after
  // the left shift and may carry a 17th bit; when that bit is set the value
  // already exceeds any 16-bit divisor, so the trial always succeeds and the
  // low 16 bits of the 17-bit difference are still exact.
  // Returns {no_borrow, difference[15:0]}.
  function automatic logic [CALC_NBITS:0] calc_trial_sub(
    input logic [CALC_NBITS:0]   shifted,
    input logic [CALC_NBITS-1:0] divisor
  );
    logic [CALC_NBITS:0] diff;
    diff = {1'b0, shifted[CALC_NBITS-1:0]} - {1'b0, divisor};
    calc_trial_sub = {shifted[CALC_NBITS] | ~diff[CALC_NBITS],
                      diff[CALC_NBITS-1:0]};
  endfunction

endpackage

// File: rtl/iter_calc_inv_dpath.sv
// Datapath of the inverse calculator: operand/remainder/quotient registers,
// the 17-bit trial subtractor and the iteration counter. The quotient
// register doubles as the result register for subtraction.
module iter_calc_inv_dpath
  import calc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  step_en,
  input  logic                  op,
  input  logic [CALC_NBITS-1:0] in0,
  input  logic [CALC_NBITS-1:0] in1,
  output logic                  count_done,
  output logic [CALC_NBITS-1:0] result,
  output logic [CALC_NBITS-1:0] remainder
);

  localparam logic [CALC_CNT_BITS-1:0] CNT_LAST = CALC_CNT_BITS'(CALC_NBITS - 1);

  logic [CALC_NBITS-1:0]    quo_r;
  logic [CALC_NBITS-1:0]    rem_r;
  logic [CALC_NBITS-1:0]    div_r;
  logic [CALC_CNT_BITS-1:0] cnt_r;

  logic [CALC_NBITS:0]      shifted_s;
  logic [CALC_NBITS:0]      trial_s;
  logic                     no_borrow_s;
  logic [CALC_NBITS-1:0]    rem_next_s;

  // Shift {rem,quo} left by one and run the trial subtraction against the divisor.
  always_comb begin
    shifted_s   = {rem_r, quo_r[CALC_NBITS-1]};
    trial_s     = calc_trial_sub(shifted_s, div_r);
    no_borrow_s = trial_s[CALC_NBITS];
    if (no_borrow_s) begin
      rem_next_s = trial_s[CALC_NBITS-1:0];
    end else begin
      rem_next_s = shifted_s[CALC_NBITS-1:0];
    end
  end

  // Operand capture on accept, one restoring-division iteration per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_r <= {CALC_NBITS{1'b0}};
      rem_r <= {CALC_NBITS{1'b0}};
      div_r <= {CALC_NBITS{1'b0}};
      cnt_r <= {CALC_CNT_BITS{1'b0}};
    end else if (load_en) begin
      rem_r <= {CALC_NBITS{1'b0}};
      div_r <= in1;
      cnt_r <= {CALC_CNT_BITS{1'b0}};
      if (op == CALC_OP_DIV) begin
        quo_r <= in0;
      end else begin
        quo_r <= in0 - in1;
      end
    end else if (step_en) begin
      quo_r <= {quo_r[CALC_NBITS-2:0], no_borrow_s};
      rem_r <= rem_next_s;
      cnt_r <= cnt_r + {{(CALC_CNT_BITS-1){1'b0}}, 1'b1};
    end else begin
      quo_r <= quo_r;
      rem_r <= rem_r;
      div_r <= div_r;
      cnt_r <= cnt_r;
    end
  end

  assign count_done = (cnt_r == CNT_LAST);
  assign result     = quo_r;
  assign remainder  = rem_r;

endmodule

// File: rtl/iter_calc_inv.sv
// Iterative inverse calculator: subtract in one cycle or unsigned restoring
// divide in sixteen, with val/rdy handshakes on both sides. This module is
// the control FSM; the arithmetic lives in iter_calc_inv_dpath.
module iter_calc_inv
  import calc_pkg::*;
#(
  parameter int NBITS = CALC_NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in0,
  input  logic [NBITS-1:0] in1,
  input  logic             op,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] result,
  output logic [NBITS-1:0] remainder
);

  calc_state_t state_r;
  calc_state_t next_state_s;
  logic        load_s;
  logic        step_s;
  logic        count_done_s;
  logic        in_rdy_r;
  logic        out_val_r;

  // Next-state and datapath enables; accept only in IDLE, release only on out_rdy.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_val) begin
          load_s = 1'b1;
          if (op == CALC_OP_DIV) begin
            next_state_s = CALC;
          end else begin
            next_state_s = DONE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        step_s = 1'b1;
        if (count_done_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = CALC;
        end
      end
      DONE: begin
        if (out_rdy) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register with handshake flags registered from the next state,
  // so in_rdy/out_val always equal the decode of the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_rdy_r  <= 1'b1;
      out_val_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      in_rdy_r  <= (next_state_s == IDLE);
      out_val_r <= (next_state_s == DONE);
    end
  end

  iter_calc_inv_dpath u_dpath (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_s),
    .step_en    (step_s),
    .op         (op),
    .in0        (in0),
    .in1        (in1),
    .count_done (count_done_s),
    .result     (result),
    .remainder  (remainder)
  );

  assign in_rdy  = in_rdy_r;
  assign out_val = out_val_r;

endmodule

// File: tb/tb_iter_calc_inv.sv
// Directed and random self-checking bench for iter_calc_inv.
module tb_iter_calc_inv;

  logic        clk;
  logic        rst;
  logic        in_val;
  logic        in_rdy;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        op;
  logic        out_val;
  logic        out_rdy;
  logic [15:0] result;
  logic [15:0] remainder;

  int n_checks = 0;
  int n_errors = 0;

  iter_calc_inv dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in0       (in0),
    .in1       (in1),
    .op        (op),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .result    (result),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it through to the result transfer.
  task automatic run_req(input logic [15:0] a, input logic [15:0] b, input logic o,
                         input logic [15:0] er, input logic [15:0] erem,
                         input int stall, input bit poke);
    int cyc;
    int lat;
    lat = o ? 17 : 1;
    cyc = 0;
    while (!in_rdy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("in_rdy_before_req", in_rdy, 1'b1);
    in0 = a; in1 = b; op = o; in_val = 1'b1;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    in0 = 16'($urandom); in1 = 16'($urandom); op = 1'($urandom);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (poke) in_val = ~in_val;
    end while (!out_val && cyc < 40);
    chk("latency", cyc, lat);
    chk("result", result, er);
    chk("remainder", remainder, erem);
    repeat (stall) begin
      @(negedge clk);
      if (poke) in_val = 1'b1;
      chk("stall_out_val", out_val, 1'b1);
      chk("stall_in_rdy", in_rdy, 1'b0);
      chk("stall_result", result, er);
      chk("stall_remainder", remainder, erem);
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
    @(negedge clk);
    chk("post_xfer_out_val", out_val, 1'b0);
    chk("post_xfer_in_rdy", in_rdy, 1'b1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        ro;
    logic [15:0] er;
    logic [15:0] erem;
    bit          seen;

    rst = 1'b1; in_val = 1'b0; in0 = 16'd0; in1 = 16'd0; op = 1'b0; out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_rdy", in_rdy, 1'b1);
    chk("reset_out_val", out_val, 1'b0);
    chk("reset_result", result, 16'd0);
    chk("reset_remainder", remainder, 16'd0);

    // Subtract
    run_req(16'd5, 16'd3, 1'b0, 16'd2, 16'd0, 0, 1'b0);
    run_req(16'd0, 16'd1, 1'b0, 16'hFFFF, 16'd0, 0, 1'b0);
    run_req(16'h8000, 16'h8000, 1'b0, 16'd0, 16'd0, 0, 1'b0);

    // Divide
    run_req(16'd100, 16'd7, 1'b1, 16'd14, 16'd2, 0, 1'b0);
    run_req(16'd65535, 16'd3, 1'b1, 16'd21845, 16'd0, 0, 1'b0);
    run_req(16'd3, 16'd65535, 1'b1, 16'd0, 16'd3, 0, 1'b0);
    run_req(16'h04D2, 16'd0, 1'b1, 16'hFFFF, 16'h04D2, 0, 1'b0);

    // Backpressure with ignored in_val pulses, then a follow-up subtract
    run_req(16'd100, 16'd7, 1'b1, 16'd14, 16'd2, 5, 1'b1);
    run_req(16'd9, 16'd4, 1'b0, 16'd5, 16'd0, 0, 1'b0);

    // Reset at iteration 8 of a divide
    in0 = 16'd1000; in1 = 16'd10; op = 1'b1; in_val = 1'b1;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_val", out_val, 1'b0);
    chk("abort_in_rdy", in_rdy, 1'b1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_val) seen = 1'b1;
    end
    chk("abort_no_result", seen, 1'b0);
    run_req(16'd1000, 16'd10, 1'b1, 16'd100, 16'd0, 0, 1'b0);

    // Random requests
    for (int i = 0; i < 50; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 16'd0;
        1: rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      ro = 1'($urandom_range(0, 1));
      if (!ro) begin
        er = ra - rb; erem = 16'd0;
      end else if (rb == 16'd0) begin
        er = 16'hFFFF; erem = ra;
      end else begin
        er = ra / rb; erem = ra % rb;
      end
      run_req(ra, rb, ro, er, erem, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
